quad_step_decoder: RTL and testbench



---
 rtl/quad_pkg.sv | 26 ++
 rtl/quad_glitch_filter.sv | 56 +++++
 rtl/quad_step_decoder.sv | 149 ++++++++++++++
 tb/tb_quad_step_decoder.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and Gray-code helpers for the quadrature step decoder.
package quad_pkg;

    typedef enum logic {INIT, TRACK} fsm_t;

    typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR} step_t;

    // Channel levels packed as {A,B}, listed in forward rotation order.
    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q10 = 2'b10;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q01 = 2'b01;

    // Forward successor of a Gray level: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] next_fwd(input logic [1:0] ab);
        logic [1:0] nf;
        case (ab)
            Q00:     nf = Q10;
            Q10:     nf = Q11;
            Q11:     nf = Q01;
            default: nf = Q00;
        endcase
        return nf;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One quadrature channel: metastability synchronizer followed by a
// persistence filter that only passes levels held for FILTER_LEN cycles.
module quad_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic Clock_i,
    input  logic Reset_n_i,
    input  logic raw_i,
    input  logic load_i,
    output logic filt_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   filt_q, filt_d;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Shift the raw level through the synchronizer chain.
    always_ff @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) sync_q <= '0;
        else            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end

    // Filtered level follows the synchronized level only after it has
    // disagreed for FILTER_LEN consecutive cycles; load_i bypasses this.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (load_i) begin
            filt_d = sync_lvl;
        end else if (sync_lvl != filt_q) begin
            if (cnt_q == CNT_LAST) filt_d = sync_lvl;
            else                   cnt_d  = cnt_q + CW'(1);
        end
    end

    // Filter state registers.
    always_ff @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature input front end: filters both channels, decodes Gray
// transitions and accumulates them into one Up/Down pulse per detent.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int DETENT_DIV  = 4
) (
    input  logic Clock_i,
    input  logic Reset_n_i,
    input  logic QuadA_i,
    input  logic QuadB_i,
    input  logic Enable_i,
    input  logic ErrorClr_i,
    output logic Up_o,
    output logic Down_o,
    output logic Error_o
);

    localparam int AW       = $clog2(DETENT_DIV) + 1;
    localparam int INIT_CYC = SYNC_STAGES + FILTER_LEN;
    localparam int IW       = $clog2(INIT_CYC + 1);

    localparam logic signed [AW-1:0] ACC_MAX = AW'(DETENT_DIV - 1);
    localparam logic signed [AW-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [AW-1:0] ACC_ONE = AW'(1);

    logic                 filt_a, filt_b;
    logic [1:0]           filt_ab, prev_q;
    fsm_t                 state_q;
    logic [IW-1:0]        init_cnt_q;
    logic                 load;
    step_t                step;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 up_q, up_d, dn_q, dn_d, err_q, err_d;

    // While in INIT the filters adopt the synchronized levels directly so
    // whatever level the inputs rest at becomes the starting reference.
    assign load = (state_q == INIT);

    quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .Clock_i  (Clock_i),
        .Reset_n_i(Reset_n_i),
        .raw_i    (QuadA_i),
        .load_i   (load),
        .filt_o   (filt_a)
    );

    quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .Clock_i  (Clock_i),
        .Reset_n_i(Reset_n_i),
        .raw_i    (QuadB_i),
        .load_i   (load),
        .filt_o   (filt_b)
    );

    assign filt_ab = {filt_a, filt_b};

    // Stay in INIT long enough for the synchronizer and filter to settle.
    always_ff @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (init_cnt_q == IW'(INIT_CYC - 1)) begin
                        state_q    <= TRACK;
                        init_cnt_q <= '0;
                    end else begin
                        init_cnt_q <= init_cnt_q + IW'(1);
                    end
                end
                TRACK:   state_q <= TRACK;
                default: state_q <= INIT;
            endcase
        end
    end

    // Previous filtered level, the reference for transition decode.
    always_ff @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) prev_q <= '0;
        else            prev_q <= filt_ab;
    end

    // Classify the prev -> cur transition against the Gray rotation.
    always_comb begin
        step = STEP_NONE;
        if (filt_ab == prev_q)                step = STEP_NONE;
        else if (next_fwd(prev_q) == filt_ab) step = STEP_FWD;
        else if (next_fwd(filt_ab) == prev_q) step = STEP_REV;
        else                                  step = STEP_ERR;
    end

    // Detent accumulator and pulse/error next-state; set beats clear.
    always_comb begin
        acc_d = acc_q;
        up_d  = 1'b0;
        dn_d  = 1'b0;
        err_d = err_q & ~ErrorClr_i;
        if (state_q == TRACK) begin
            case (step)
                STEP_ERR: begin
                    acc_d = '0;
                    err_d = 1'b1;
                end
                STEP_FWD: begin
                    if (acc_q == ACC_MAX) begin
                        up_d  = Enable_i;
                        acc_d = '0;
                    end else begin
                        acc_d = acc_q + ACC_ONE;
                    end
                end
                STEP_REV: begin
                    if (acc_q == ACC_MIN) begin
                        dn_d  = Enable_i;
                        acc_d = '0;
                    end else begin
                        acc_d = acc_q - ACC_ONE;
                    end
                end
                default: acc_d = acc_q;
            endcase
        end
        if (!Enable_i) acc_d = '0;
    end

    // Registered accumulator and outputs.
    always_ff @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            acc_q <= '0;
            up_q  <= 1'b0;
            dn_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            up_q  <= up_d;
            dn_q  <= dn_d;
            err_q <= err_d;
        end
    end

    assign Up_o    = up_q;
    assign Down_o  = dn_q;
    assign Error_o = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: default instance plus a DETENT_DIV=1 instance
// sharing the same stimulus, checked against a rotation-phase model.
module tb_quad_step_decoder;
    import quad_pkg::*;

    logic Clock_i = 1'b0;
    logic Reset_n_i, QuadA_i, QuadB_i, Enable_i, ErrorClr_i;
    logic up0, dn0, err0, up1, dn1, err1;

    always #5 Clock_i = ~Clock_i;

    quad_step_decoder dut (
        .Clock_i(Clock_i), .Reset_n_i(Reset_n_i), .QuadA_i(QuadA_i), .QuadB_i(QuadB_i),
        .Enable_i(Enable_i), .ErrorClr_i(ErrorClr_i),
        .Up_o(up0), .Down_o(dn0), .Error_o(err0)
    );

    quad_step_decoder #(.DETENT_DIV(1)) dut1 (
        .Clock_i(Clock_i), .Reset_n_i(Reset_n_i), .QuadA_i(QuadA_i), .QuadB_i(QuadB_i),
        .Enable_i(Enable_i), .ErrorClr_i(ErrorClr_i),
        .Up_o(up1), .Down_o(dn1), .Error_o(err1)
    );

    int checks = 0, errors = 0;

    // Observed pulse counts, sampled 1 time unit after each rising edge.
    int up0_n = 0, dn0_n = 0, up1_n = 0, dn1_n = 0, both_n = 0, fchg_n = 0;
    logic [1:0] last_filt = 2'b00;
    always begin
        @(posedge Clock_i);
        #1;
        if (up0 === 1'b1) up0_n++;
        if (dn0 === 1'b1) dn0_n++;
        if (up1 === 1'b1) up1_n++;
        if (dn1 === 1'b1) dn1_n++;
        if ((up0 & dn0) === 1'b1 || (up1 & dn1) === 1'b1) both_n++;
        if (dut.filt_ab !== last_filt) fchg_n++;
        last_filt = dut.filt_ab;
    end

    // Reference model: rotation phase index 0..3, step = phase difference mod 4.
    int m_up0 = 0, m_dn0 = 0, m_up1 = 0, m_dn1 = 0, m_acc0 = 0, m_acc1 = 0;
    bit m_err = 0, m_en = 1;
    logic [1:0] m_lvl = 2'b00;

    function automatic int phase(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic acc_step(input int d, input int div, inout int acc, inout int np, inout int nn);
        if (!m_en) acc = 0;
        else if (d == 1) begin
            if (acc == div - 1) begin np++; acc = 0; end else acc++;
        end else if (d == 3) begin
            if (acc == -(div - 1)) begin nn++; acc = 0; end else acc--;
        end
    endtask

    task automatic model_move(input logic [1:0] nl);
        int d;
        d = (phase(nl) - phase(m_lvl) + 4) % 4;
        m_lvl = nl;
        if (d == 2) begin
            m_err = 1; m_acc0 = 0; m_acc1 = 0;
        end else if (d != 0) begin
            acc_step(d, 4, m_acc0, m_up0, m_dn0);
            acc_step(d, 1, m_acc1, m_up1, m_dn1);
        end
    endtask

    task automatic set_enable(input bit en);
        Enable_i = en;
        m_en = en;
        if (!en) begin m_acc0 = 0; m_acc1 = 0; end
    endtask

    // Drive a new clean level and let it propagate well past the pulse latency.
    task automatic move(input logic [1:0] nl);
        @(negedge Clock_i);
        {QuadA_i, QuadB_i} = nl;
        model_move(nl);
        repeat (12) @(negedge Clock_i);
    endtask

    task automatic do_reset(input logic [1:0] lvl);
        @(negedge Clock_i);
        Reset_n_i = 1'b0;
        {QuadA_i, QuadB_i} = lvl;
        ErrorClr_i = 1'b0;
        set_enable(1'b1);
        repeat (2) @(negedge Clock_i);
        Reset_n_i = 1'b1;
        m_lvl = lvl; m_acc0 = 0; m_acc1 = 0; m_err = 0;
        repeat (10) @(negedge Clock_i);
    endtask

    task automatic test_reset();
        int su, sd;
        Reset_n_i = 1'b0; QuadA_i = 1'b1; QuadB_i = 1'b1; ErrorClr_i = 1'b0;
        set_enable(1'b1);
        #12;
        checks++;
        if ({up0, dn0, err0} !== 3'b000) begin
            errors++; $display("FAIL reset_outputs: got %b expected 000", {up0, dn0, err0});
        end
        @(negedge Clock_i);
        Reset_n_i = 1'b1;
        m_lvl = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            @(posedge Clock_i);
            #1;
            if (k == 5) begin
                checks++;
                if (dut.state_q !== INIT) begin
                    errors++; $display("FAIL init_hold: state %0d expected INIT at cycle 5", dut.state_q);
                end
            end
            if (k == 6) begin
                checks++;
                if (dut.state_q !== TRACK) begin
                    errors++; $display("FAIL track_entry: state %0d expected TRACK at cycle 6", dut.state_q);
                end
            end
        end
        su = up0_n + up1_n; sd = dn0_n + dn1_n;
        repeat (30) @(negedge Clock_i);
        checks++;
        if (su !== 0 || sd !== 0 || up0_n + up1_n !== 0 || dn0_n + dn1_n !== 0 || {err0, err1} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset: ups=%0d downs=%0d err=%b expected 0 0 00",
                     up0_n + up1_n, dn0_n + dn1_n, {err0, err1});
        end
    endtask

    task automatic test_forward_reverse();
        int lat;
        do_reset(2'b00);
        move(2'b10); move(2'b11); move(2'b01);
        @(negedge Clock_i);
        {QuadA_i, QuadB_i} = 2'b00;
        model_move(2'b00);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clock_i);
            #1;
            if (lat == 0 && up0 === 1'b1) lat = k;
        end
        checks++;
        if (lat !== 7) begin
            errors++; $display("FAIL up_latency: got %0d cycles expected 7", lat);
        end
        @(negedge Clock_i);
        checks++;
        if (up0_n !== m_up0 || dn0_n !== m_dn0 || up1_n !== m_up1 || dn1_n !== m_dn1) begin
            errors++;
            $display("FAIL fwd_detent: up0=%0d dn0=%0d up1=%0d dn1=%0d expected %0d %0d %0d %0d",
                     up0_n, dn0_n, up1_n, dn1_n, m_up0, m_dn0, m_up1, m_dn1);
        end
        move(2'b01); move(2'b11); move(2'b10); move(2'b00);
        checks++;
        if (up0_n !== m_up0 || dn0_n !== m_dn0 || up1_n !== m_up1 || dn1_n !== m_dn1) begin
            errors++;
            $display("FAIL rev_detent: up0=%0d dn0=%0d up1=%0d dn1=%0d expected %0d %0d %0d %0d",
                     up0_n, dn0_n, up1_n, dn1_n, m_up0, m_dn0, m_up1, m_dn1);
        end
    endtask

    task automatic test_glitch();
        int f0;
        do_reset(2'b00);
        f0 = fchg_n;
        @(negedge Clock_i); QuadA_i = 1'b1;
        repeat (3) @(negedge Clock_i); QuadA_i = 1'b0;
        repeat (12) @(negedge Clock_i);
        checks++;
        if (fchg_n !== f0) begin
            errors++; $display("FAIL glitch_3cyc: filtered changes %0d expected 0", fchg_n - f0);
        end
        // A 4-cycle pulse passes the filter both ways: rise then fall.
        @(negedge Clock_i); QuadA_i = 1'b1; model_move(2'b10);
        repeat (4) @(negedge Clock_i); QuadA_i = 1'b0; model_move(2'b00);
        repeat (14) @(negedge Clock_i);
        checks++;
        if (fchg_n - f0 !== 2) begin
            errors++; $display("FAIL glitch_4cyc: filtered changes %0d expected 2", fchg_n - f0);
        end
        move(2'b10);
        checks++;
        if (up0_n !== m_up0 || dn0_n !== m_dn0) begin
            errors++; $display("FAIL glitch_acc1: up0=%0d dn0=%0d expected %0d %0d", up0_n, dn0_n, m_up0, m_dn0);
        end
        move(2'b11); move(2'b01); move(2'b00);
        checks++;
        if (up0_n !== m_up0 || dn0_n !== m_dn0 || up1_n !== m_up1 || dn1_n !== m_dn1) begin
            errors++;
            $display("FAIL glitch_detent: up0=%0d dn0=%0d up1=%0d dn1=%0d expected %0d %0d %0d %0d",
                     up0_n, dn0_n, up1_n, dn1_n, m_up0, m_dn0, m_up1, m_dn1);
        end
    endtask

    task automatic test_error();
        do_reset(2'b00);
        move(2'b10);
        move(2'b01);
        checks++;
        if (err0 !== 1'b1 || err1 !== 1'b1 || up0_n !== m_up0 || dn0_n !== m_dn0) begin
            errors++; $display("FAIL err_set: err=%b%b up0=%0d dn0=%0d expected 11 %0d %0d",
                               err0, err1, up0_n, dn0_n, m_up0, m_dn0);
        end
        @(negedge Clock_i); ErrorClr_i = 1'b1;
        @(negedge Clock_i); ErrorClr_i = 1'b0; m_err = 0;
        checks++;
        if (err0 !== 1'b0) begin
            errors++; $display("FAIL err_clear: got %b expected 0", err0);
        end
        move(2'b00); move(2'b10); move(2'b11);
        checks++;
        if (up0_n !== m_up0) begin
            errors++; $display("FAIL err_acc_zero: up0=%0d expected %0d", up0_n, m_up0);
        end
        move(2'b01);
        checks++;
        if (up0_n !== m_up0) begin
            errors++; $display("FAIL err_then_detent: up0=%0d expected %0d", up0_n, m_up0);
        end
        // Illegal jump whose error lands on the same edge as a clear.
        @(negedge Clock_i);
        {QuadA_i, QuadB_i} = 2'b10;
        model_move(2'b10);
        repeat (6) @(negedge Clock_i);
        checks++;
        if (err0 !== 1'b0) begin
            errors++; $display("FAIL err_pre_collide: got %b expected 0", err0);
        end
        ErrorClr_i = 1'b1;
        @(negedge Clock_i); ErrorClr_i = 1'b0;
        checks++;
        if (err0 !== 1'b1 || err1 !== 1'b1) begin
            errors++; $display("FAIL err_set_wins: got %b%b expected 11", err0, err1);
        end
        repeat (6) @(negedge Clock_i);
    endtask

    task automatic test_reversal();
        do_reset(2'b00);
        move(2'b10); move(2'b11); move(2'b01);
        move(2'b11); move(2'b10); move(2'b00);
        checks++;
        if (up0_n !== m_up0 || dn0_n !== m_dn0) begin
            errors++; $display("FAIL reversal_unwind: up0=%0d dn0=%0d expected %0d %0d", up0_n, dn0_n, m_up0, m_dn0);
        end
        move(2'b01);
        checks++;
        if (dn0_n !== m_dn0) begin
            errors++; $display("FAIL reversal_acc_m1: dn0=%0d expected %0d", dn0_n, m_dn0);
        end
        move(2'b11); move(2'b10); move(2'b00);
        checks++;
        if (dn0_n !== m_dn0 || up0_n !== m_up0) begin
            errors++; $display("FAIL reversal_detent: up0=%0d dn0=%0d expected %0d %0d", up0_n, dn0_n, m_up0, m_dn0);
        end
    endtask

    task automatic test_enable_dd1();
        do_reset(2'b00);
        @(negedge Clock_i); set_enable(1'b0);
        move(2'b10); move(2'b11); move(2'b01); move(2'b00);
        checks++;
        if (up1_n !== m_up1 || up0_n !== m_up0) begin
            errors++; $display("FAIL disabled_steps: up0=%0d up1=%0d expected %0d %0d", up0_n, up1_n, m_up0, m_up1);
        end
        @(negedge Clock_i); set_enable(1'b1);
        move(2'b10);
        checks++;
        if (up1_n !== m_up1 || up0_n !== m_up0) begin
            errors++; $display("FAIL reenable_step: up0=%0d up1=%0d expected %0d %0d", up0_n, up1_n, m_up0, m_up1);
        end
        move(2'b01);
        @(negedge Clock_i);
        {QuadA_i, QuadB_i} = 2'b00;
        model_move(2'b00);
        repeat (7) @(posedge Clock_i);
        #1;
        checks++;
        if (up1 !== 1'b1 || err1 !== 1'b1) begin
            errors++; $display("FAIL pre_async_reset: up1=%b err1=%b expected 1 1", up1, err1);
        end
        #1 Reset_n_i = 1'b0;
        #1;
        checks++;
        if ({up0, dn0, err0, up1, dn1, err1} !== 6'b0) begin
            errors++; $display("FAIL async_reset: outputs %b expected 000000", {up0, dn0, err0, up1, dn1, err1});
        end
        @(negedge Clock_i);
        Reset_n_i = 1'b1;
        m_acc0 = 0; m_acc1 = 0; m_err = 0;
        repeat (10) @(negedge Clock_i);
    endtask

    task automatic test_random();
        logic [1:0] nl;
        int r, ch, len;
        do_reset(2'($urandom_range(0, 3)));
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 4) == 0) set_enable(!m_en);
            if (r <= 3) move(next_fwd(m_lvl));
            else if (r <= 6) begin
                nl = m_lvl;
                for (int c = 0; c < 4; c++)
                    if (next_fwd(2'(c)) == m_lvl) nl = 2'(c);
                move(nl);
            end else if (r == 7) move(next_fwd(next_fwd(m_lvl)));
            else if (r == 8) begin
                ch = $urandom_range(0, 1); len = $urandom_range(1, 3);
                @(negedge Clock_i);
                if (ch == 0) QuadA_i = ~QuadA_i; else QuadB_i = ~QuadB_i;
                repeat (len) @(negedge Clock_i);
                {QuadA_i, QuadB_i} = m_lvl;
                repeat (12) @(negedge Clock_i);
            end else begin
                @(negedge Clock_i); ErrorClr_i = 1'b1;
                @(negedge Clock_i); ErrorClr_i = 1'b0; m_err = 0;
            end
            checks++;
            if (up0_n !== m_up0 || dn0_n !== m_dn0 || up1_n !== m_up1 || dn1_n !== m_dn1 ||
                err0 !== m_err || err1 !== m_err) begin
                errors++;
                $display("FAIL random_%0d: up0=%0d dn0=%0d up1=%0d dn1=%0d err=%b%b expected %0d %0d %0d %0d %b",
                         it, up0_n, dn0_n, up1_n, dn1_n, err0, err1, m_up0, m_dn0, m_up1, m_dn1, m_err);
            end
        end
        checks++;
        if (both_n !== 0) begin
            errors++; $display("FAIL up_down_exclusive: %0d overlapping cycles expected 0", both_n);
        end
    endtask

    initial begin
        test_reset();
        test_forward_reverse();
        test_glitch();
        test_error();
        test_reversal();
        test_enable_dd1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
